// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I decode stage.
package decode_pkg;

   typedef enum logic [3:0] {
      OP_MATH   = 4'd0,
      OP_MEM    = 4'd1,
      OP_BRANCH = 4'd2,
      OP_UPPER  = 4'd3,
      OP_MULDIV = 4'd4
   } op_type_e;

   localparam logic [4:0] SPEC_ADD  = 5'd0;
   localparam logic [4:0] SPEC_SUB  = 5'd1;
   localparam logic [4:0] SPEC_XOR  = 5'd2;
   localparam logic [4:0] SPEC_OR   = 5'd3;
   localparam logic [4:0] SPEC_AND  = 5'd4;
   localparam logic [4:0] SPEC_SLL  = 5'd5;
   localparam logic [4:0] SPEC_SRL  = 5'd6;
   localparam logic [4:0] SPEC_SRA  = 5'd7;
   localparam logic [4:0] SPEC_SLT  = 5'd8;
   localparam logic [4:0] SPEC_SLTU = 5'd9;

   localparam logic [4:0] SPEC_LB  = 5'd0;
   localparam logic [4:0] SPEC_LH  = 5'd1;
   localparam logic [4:0] SPEC_LW  = 5'd2;
   localparam logic [4:0] SPEC_LBU = 5'd3;
   localparam logic [4:0] SPEC_LHU = 5'd4;
   localparam logic [4:0] SPEC_SB  = 5'd5;
   localparam logic [4:0] SPEC_SH  = 5'd6;
   localparam logic [4:0] SPEC_SW  = 5'd7;

   localparam logic [4:0] SPEC_BEQ  = 5'd0;
   localparam logic [4:0] SPEC_BNE  = 5'd1;
   localparam logic [4:0] SPEC_BLT  = 5'd2;
   localparam logic [4:0] SPEC_BGE  = 5'd3;
   localparam logic [4:0] SPEC_BLTU = 5'd4;
   localparam logic [4:0] SPEC_BGEU = 5'd5;
   localparam logic [4:0] SPEC_JAL  = 5'd6;
   localparam logic [4:0] SPEC_JALR = 5'd7;

   localparam logic [4:0] SPEC_LUI   = 5'd0;
   localparam logic [4:0] SPEC_AUIPC = 5'd1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      op_type_e    op_type;
      logic [4:0]  op_spec;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        illegal;
   } decoded_t;

   // alt selects sub/sra over add/srl
   function automatic logic [4:0] alu_spec(input logic [2:0] funct3, input logic alt);
      logic [4:0] spec;
      case (funct3)
         3'b000:  spec = alt ? SPEC_SUB : SPEC_ADD;
         3'b001:  spec = SPEC_SLL;
         3'b010:  spec = SPEC_SLT;
         3'b011:  spec = SPEC_SLTU;
         3'b100:  spec = SPEC_XOR;
         3'b101:  spec = alt ? SPEC_SRA : SPEC_SRL;
         3'b110:  spec = SPEC_OR;
         3'b111:  spec = SPEC_AND;
         default: spec = SPEC_ADD;
      endcase
      return spec;
   endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational RV32I decoder for one instruction word.
// Optional feature macro DECODE_MEXT_EN: funct7 0000001 on OP decodes as muldiv.
module decode_lane
   import decode_pkg::*;
(
   input  logic [31:0] op,
   output decoded_t    dec
);

   logic [6:0]  opcode_s;
   logic [6:0]  funct7_s;
   logic [2:0]  funct3_s;
   logic [31:0] imm_i_s;
   logic [31:0] imm_st_s;
   logic [31:0] imm_b_s;
   logic [31:0] imm_u_s;
   logic [31:0] imm_j_s;
   logic        r_f7_ok_s;
   logic        sh_f7_ok_s;
   logic        sh_s;
   op_type_e    type_s;
   logic [4:0]  spec_s;
   logic [4:0]  rd_s;
   logic [4:0]  rs2_s;
   logic [31:0] imm_s;
   logic        illegal_s;

   assign opcode_s = op[6:0];
   assign funct3_s = op[14:12];
   assign funct7_s = op[31:25];

   assign imm_i_s  = {{20{op[31]}}, op[31:20]};
   assign imm_st_s = {{20{op[31]}}, op[31:25], op[11:7]};
   assign imm_b_s  = {{19{op[31]}}, op[31], op[7], op[30:25], op[11:8], 1'b0};
   assign imm_u_s  = {op[31:12], 12'h000};
   assign imm_j_s  = {{11{op[31]}}, op[31], op[19:12], op[20], op[30:21], 1'b0};

   // funct7 0100000 is only meaningful for sub and sra
   assign sh_s       = (funct3_s == 3'b001) || (funct3_s == 3'b101);
   assign sh_f7_ok_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
   assign r_f7_ok_s  = (funct7_s == F7_BASE) ||
                       ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));

   // classify opcode, pick spec and immediate format, mask unused registers
   always_comb begin
      type_s    = OP_MATH;
      spec_s    = SPEC_ADD;
      imm_s     = 32'h0000_0000;
      rd_s      = op[11:7];
      rs2_s     = op[24:20];
      illegal_s = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            if (funct7_s == F7_MULDIV) begin
`ifdef DECODE_MEXT_EN
               type_s = OP_MULDIV;
               spec_s = {2'b00, funct3_s};
`else
               illegal_s = 1'b1;
`endif
            end else begin
               spec_s    = alu_spec(funct3_s, op[30]);
               illegal_s = !r_f7_ok_s;
            end
         end
         OPC_OP_IMM: begin
            spec_s    = alu_spec(funct3_s, op[30] && (funct3_s == 3'b101));
            imm_s     = imm_i_s;
            rs2_s     = 5'd0;
            illegal_s = sh_s && !sh_f7_ok_s;
         end
         OPC_LOAD: begin
            type_s = OP_MEM;
            imm_s  = imm_i_s;
            rs2_s  = 5'd0;
            case (funct3_s)
               3'b000:  spec_s = SPEC_LB;
               3'b001:  spec_s = SPEC_LH;
               3'b010:  spec_s = SPEC_LW;
               3'b100:  spec_s = SPEC_LBU;
               3'b101:  spec_s = SPEC_LHU;
               default: illegal_s = 1'b1;
            endcase
         end
         OPC_STORE: begin
            type_s = OP_MEM;
            imm_s  = imm_st_s;
            rd_s   = 5'd0;
            case (funct3_s)
               3'b000:  spec_s = SPEC_SB;
               3'b001:  spec_s = SPEC_SH;
               3'b010:  spec_s = SPEC_SW;
               default: illegal_s = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            type_s = OP_BRANCH;
            imm_s  = imm_b_s;
            rd_s   = 5'd0;
            case (funct3_s)
               3'b000:  spec_s = SPEC_BEQ;
               3'b001:  spec_s = SPEC_BNE;
               3'b100:  spec_s = SPEC_BLT;
               3'b101:  spec_s = SPEC_BGE;
               3'b110:  spec_s = SPEC_BLTU;
               3'b111:  spec_s = SPEC_BGEU;
               default: illegal_s = 1'b1;
            endcase
         end
         OPC_JAL: begin
            type_s = OP_BRANCH;
            spec_s = SPEC_JAL;
            imm_s  = imm_j_s;
            rs2_s  = 5'd0;
         end
         OPC_JALR: begin
            type_s    = OP_BRANCH;
            spec_s    = SPEC_JALR;
            imm_s     = imm_i_s;
            rs2_s     = 5'd0;
            illegal_s = (funct3_s != 3'b000);
         end
         OPC_LUI: begin
            type_s = OP_UPPER;
            spec_s = SPEC_LUI;
            imm_s  = imm_u_s;
            rs2_s  = 5'd0;
         end
         OPC_AUIPC: begin
            type_s = OP_UPPER;
            spec_s = SPEC_AUIPC;
            imm_s  = imm_u_s;
            rs2_s  = 5'd0;
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // illegal encodings collapse to a zeroed math op
   always_comb begin
      dec         = '0;
      dec.rd      = rd_s;
      dec.rs1     = op[19:15];
      dec.rs2     = rs2_s;
      dec.illegal = illegal_s;
      if (illegal_s) begin
         dec.op_type = OP_MATH;
         dec.op_spec = 5'd0;
         dec.imm     = 32'h0000_0000;
      end else begin
         dec.op_type = type_s;
         dec.op_spec = spec_s;
         dec.imm     = imm_s;
      end
   end

endmodule

// File: rtl/decode_pipe.sv
// Registered multi-lane RV32I decode stage with a 2-entry skid buffer.
// Optional feature macro DECODE_MEXT_EN (handled in decode_lane) enables M-extension decode.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int LANES = 1,
   parameter int XLEN  = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*32-1:0]   in_op,
   input  logic [LANES-1:0]      in_lane_vld,
   input  logic [31:0]           in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES-1:0]      out_lane_vld,
   output logic [LANES*4-1:0]    out_op_type,
   output logic [LANES*5-1:0]    out_op_spec,
   output logic [LANES*32-1:0]   out_imm,
   output logic [LANES*5-1:0]    out_rd,
   output logic [LANES*5-1:0]    out_rs1,
   output logic [LANES*5-1:0]    out_rs2,
   output logic [LANES-1:0]      out_illegal,
   output logic [LANES*32-1:0]   out_pc
);

   if (XLEN != 32) begin : g_xlen_chk
      $fatal(1, "decode_pipe: only XLEN=32 is supported");
   end
   if ((LANES < 1) || (LANES > 4)) begin : g_lanes_chk
      $fatal(1, "decode_pipe: LANES must be 1..4");
   end

   typedef struct packed {
      logic [LANES-1:0]       lane;
      decoded_t [LANES-1:0]   dec;
      logic [LANES-1:0][31:0] pc;
   } bundle_t;

   decoded_t [LANES-1:0]   in_dec_s;
   logic [LANES-1:0][31:0] in_pc_s;
   bundle_t                in_bundle_s;
   bundle_t                prim_r;
   bundle_t                skid_r;
   bundle_t                prim_nxt_s;
   bundle_t                skid_nxt_s;
   logic                   prim_vld_r;
   logic                   skid_vld_r;
   logic                   in_ready_r;
   logic                   prim_vld_nxt_s;
   logic                   skid_vld_nxt_s;
   logic                   in_fire_s;
   logic                   out_fire_s;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      decoded_t raw_s;

      decode_lane u_decode_lane (
         .op  (in_op[32*i +: 32]),
         .dec (raw_s)
      );

      // masked-off lanes are still decoded but never report illegal
      assign in_dec_s[i] = '{op_type: raw_s.op_type, op_spec: raw_s.op_spec, imm: raw_s.imm,
                             rd: raw_s.rd, rs1: raw_s.rs1, rs2: raw_s.rs2,
                             illegal: raw_s.illegal && in_lane_vld[i]};
      assign in_pc_s[i]  = in_pc + (32'(i) << 2);

      assign out_op_type[4*i +: 4]  = prim_r.dec[i].op_type;
      assign out_op_spec[5*i +: 5]  = prim_r.dec[i].op_spec;
      assign out_imm[32*i +: 32]    = prim_r.dec[i].imm;
      assign out_rd[5*i +: 5]       = prim_r.dec[i].rd;
      assign out_rs1[5*i +: 5]      = prim_r.dec[i].rs1;
      assign out_rs2[5*i +: 5]      = prim_r.dec[i].rs2;
      assign out_illegal[i]         = prim_r.dec[i].illegal;
      assign out_pc[32*i +: 32]     = prim_r.pc[i];
   end

   assign in_bundle_s  = '{lane: in_lane_vld, dec: in_dec_s, pc: in_pc_s};
   assign in_fire_s    = in_valid && in_ready_r && !flush;
   assign out_fire_s   = prim_vld_r && out_ready;
   assign in_ready     = in_ready_r;
   assign out_valid    = prim_vld_r;
   assign out_lane_vld = prim_r.lane;

   // skid next state: a freed primary takes the skid entry first, else the new bundle
   always_comb begin
      prim_nxt_s     = prim_r;
      skid_nxt_s     = skid_r;
      prim_vld_nxt_s = prim_vld_r;
      skid_vld_nxt_s = skid_vld_r;
      if (flush) begin
         prim_vld_nxt_s = 1'b0;
         skid_vld_nxt_s = 1'b0;
      end else if (out_fire_s || !prim_vld_r) begin
         if (skid_vld_r) begin
            prim_nxt_s     = skid_r;
            prim_vld_nxt_s = 1'b1;
            skid_vld_nxt_s = in_fire_s;
            if (in_fire_s) begin
               skid_nxt_s = in_bundle_s;
            end else begin
               skid_nxt_s = skid_r;
            end
         end else begin
            prim_vld_nxt_s = in_fire_s;
            if (in_fire_s) begin
               prim_nxt_s = in_bundle_s;
            end else begin
               prim_nxt_s = prim_r;
            end
         end
      end else begin
         if (in_fire_s) begin
            skid_nxt_s     = in_bundle_s;
            skid_vld_nxt_s = 1'b1;
         end else begin
            skid_nxt_s     = skid_r;
         end
      end
   end

   // state registers; in_ready is registered from the next skid occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         prim_r     <= '0;
         skid_r     <= '0;
         prim_vld_r <= 1'b0;
         skid_vld_r <= 1'b0;
         in_ready_r <= 1'b1;
      end else begin
         prim_r     <= prim_nxt_s;
         skid_r     <= skid_nxt_s;
         prim_vld_r <= prim_vld_nxt_s;
         skid_vld_r <= skid_vld_nxt_s;
         in_ready_r <= !skid_vld_nxt_s;
      end
   end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench: single-lane decode vectors, then two-lane ordering, stall and flush.
module tb_decode_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        flush;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_op, a_in_pc, a_out_imm, a_out_pc;
   logic [0:0]  a_in_lane_vld, a_out_lane_vld, a_out_illegal;
   logic [3:0]  a_out_op_type;
   logic [4:0]  a_out_op_spec, a_out_rd, a_out_rs1, a_out_rs2;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [63:0] b_in_op, b_out_imm, b_out_pc;
   logic [31:0] b_in_pc;
   logic [1:0]  b_in_lane_vld, b_out_lane_vld, b_out_illegal;
   logic [7:0]  b_out_op_type;
   logic [9:0]  b_out_op_spec, b_out_rd, b_out_rs1, b_out_rs2;

   int n_cmp = 0;
   int n_err = 0;
   int sent;
   int rcvd;

   decode_pipe #(.LANES(1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
      .in_lane_vld(a_in_lane_vld), .in_pc(a_in_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_lane_vld(a_out_lane_vld),
      .out_op_type(a_out_op_type), .out_op_spec(a_out_op_spec), .out_imm(a_out_imm),
      .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
      .out_illegal(a_out_illegal), .out_pc(a_out_pc)
   );

   decode_pipe #(.LANES(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
      .in_lane_vld(b_in_lane_vld), .in_pc(b_in_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_lane_vld(b_out_lane_vld),
      .out_op_type(b_out_op_type), .out_op_spec(b_out_op_spec), .out_imm(b_out_imm),
      .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
      .out_illegal(b_out_illegal), .out_pc(b_out_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send1(input logic [31:0] op, input logic vld);
      a_in_op       = op;
      a_in_lane_vld = vld;
      a_in_valid    = 1'b1;
      @(negedge clk);
      a_in_valid    = 1'b0;
   endtask

   task automatic chk1(input string tag, input logic [3:0] t, input logic [4:0] s,
                       input logic [31:0] imm, input logic ill);
      check({tag, ".valid"}, 32'(a_out_valid), 32'd1);
      check({tag, ".type"}, 32'(a_out_op_type), 32'(t));
      check({tag, ".spec"}, 32'(a_out_op_spec), 32'(s));
      check({tag, ".imm"}, a_out_imm, imm);
      check({tag, ".illegal"}, 32'(a_out_illegal), 32'(ill));
   endtask

   // lane0: addi x(k+1),x0,k ; lane1: lui x(k+1),k
   task automatic drive2(input int k);
      logic [31:0] w0;
      logic [31:0] w1;
      w0 = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h0000_0013;
      w1 = (32'(k) << 12) | (32'(k + 1) << 7) | 32'h0000_0037;
      b_in_op       = {w1, w0};
      b_in_pc       = 32'h0000_2000 + (32'(k) << 8);
      b_in_lane_vld = 2'b11;
   endtask

   task automatic chk2(input int k);
      check($sformatf("b%0d.imm0", k), b_out_imm[31:0], 32'(k));
      check($sformatf("b%0d.imm1", k), b_out_imm[63:32], 32'(k) << 12);
      check($sformatf("b%0d.rd0", k), 32'(b_out_rd[4:0]), 32'(k + 1));
      check($sformatf("b%0d.type1", k), 32'(b_out_op_type[7:4]), 32'd3);
      check($sformatf("b%0d.pc0", k), b_out_pc[31:0], 32'h0000_2000 + (32'(k) << 8));
      check($sformatf("b%0d.pc1", k), b_out_pc[63:32], 32'h0000_2004 + (32'(k) << 8));
      check($sformatf("b%0d.ill", k), 32'(b_out_illegal), 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      a_in_valid    = 1'b0;
      a_out_ready   = 1'b1;
      a_in_op       = 32'h0000_0000;
      a_in_lane_vld = 1'b1;
      a_in_pc       = 32'h0000_1000;
      b_in_valid    = 1'b0;
      b_out_ready   = 1'b1;
      b_in_op       = 64'h0;
      b_in_lane_vld = 2'b00;
      b_in_pc       = 32'h0000_0000;
      repeat (3) @(negedge clk);

      check("rst.out_valid", 32'(a_out_valid), 32'd0);
      check("rst.in_ready", 32'(a_in_ready), 32'd1);
      check("rst.imm", a_out_imm, 32'd0);
      check("rst.pc", a_out_pc, 32'd0);
      check("rst.b_out_valid", 32'(b_out_valid), 32'd0);
      check("rst.b_lane_vld", 32'(b_out_lane_vld), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      send1(32'hFFF0_0093, 1'b1);
      chk1("addi", 4'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      check("addi.rd", 32'(a_out_rd), 32'd1);
      check("addi.rs2", 32'(a_out_rs2), 32'd0);
      check("addi.pc", a_out_pc, 32'h0000_1000);

      send1(32'h0011_2623, 1'b1);
      chk1("sw", 4'd1, 5'd7, 32'h0000_000C, 1'b0);
      check("sw.rs1", 32'(a_out_rs1), 32'd2);
      check("sw.rs2", 32'(a_out_rs2), 32'd1);
      check("sw.rd", 32'(a_out_rd), 32'd0);

      send1(32'hFE20_9EE3, 1'b1);
      chk1("bne", 4'd2, 5'd1, 32'hFFFF_FFFC, 1'b0);
      check("bne.rd", 32'(a_out_rd), 32'd0);

      send1(32'h1234_5037, 1'b1);
      chk1("lui", 4'd3, 5'd0, 32'h1234_5000, 1'b0);
      check("lui.rd", 32'(a_out_rd), 32'd0);
      check("lui.rs2", 32'(a_out_rs2), 32'd0);

      send1(32'h0000_0000, 1'b1);
      chk1("zero", 4'd0, 5'd0, 32'h0, 1'b1);

      send1(32'h0000_0000, 1'b0);
      chk1("zero_masked", 4'd0, 5'd0, 32'h0, 1'b0);
      check("zero_masked.lane", 32'(a_out_lane_vld), 32'd0);

      send1(32'h4033_5293, 1'b1);
      chk1("srai", 4'd0, 5'd7, 32'h0000_0403, 1'b0);
      check("srai.rd", 32'(a_out_rd), 32'd5);
      check("srai.rs1", 32'(a_out_rs1), 32'd6);
      check("srai.rs2", 32'(a_out_rs2), 32'd0);

      send1(32'h0420_8033, 1'b1);
      chk1("add_badf7", 4'd0, 5'd0, 32'h0, 1'b1);

      send1(32'h4020_81B3, 1'b1);
      chk1("sub", 4'd0, 5'd1, 32'h0, 1'b0);
      check("sub.rd", 32'(a_out_rd), 32'd3);
      check("sub.rs2", 32'(a_out_rs2), 32'd2);

      send1(32'h0080_00EF, 1'b1);
      chk1("jal", 4'd2, 5'd6, 32'h0000_0008, 1'b0);
      check("jal.rd", 32'(a_out_rd), 32'd1);
      check("jal.rs2", 32'(a_out_rs2), 32'd0);

      send1(32'h0000_1067, 1'b1);
      chk1("jalr_f3", 4'd0, 5'd0, 32'h0, 1'b1);

      send1(32'h0000_2063, 1'b1);
      chk1("br_f3", 4'd0, 5'd0, 32'h0, 1'b1);

      send1(32'hFFF2_C203, 1'b1);
      chk1("lbu", 4'd1, 5'd3, 32'hFFFF_FFFF, 1'b0);
      check("lbu.rd", 32'(a_out_rd), 32'd4);
      check("lbu.rs1", 32'(a_out_rs1), 32'd5);

      send1(32'h0000_1097, 1'b1);
      chk1("auipc", 4'd3, 5'd1, 32'h0000_1000, 1'b0);

      send1(32'h0220_81B3, 1'b1);
`ifdef DECODE_MEXT_EN
      chk1("mul", 4'd4, 5'd0, 32'h0, 1'b0);
`else
      chk1("mul", 4'd0, 5'd0, 32'h0, 1'b1);
`endif
      @(negedge clk);
      check("idle.out_valid", 32'(a_out_valid), 32'd0);

      // eight bundles, downstream stalled on cycles 3..5
      sent = 0;
      rcvd = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (rcvd >= 8) break;
         b_out_ready = !((cyc >= 3) && (cyc <= 5));
         b_in_valid  = (sent < 8);
         if (sent < 8) drive2(sent);
         if (cyc == 3) check("stall.ready_c3", 32'(b_in_ready), 32'd1);
         if (cyc == 4) check("stall.ready_c4", 32'(b_in_ready), 32'd0);
         if (cyc == 4) check("stall.sent_c4", 32'(sent), 32'd4);
         if (cyc == 6) check("stall.ready_c6", 32'(b_in_ready), 32'd0);
         if (cyc == 7) check("stall.ready_c7", 32'(b_in_ready), 32'd1);
         if (b_out_valid && b_out_ready) begin
            chk2(rcvd);
            rcvd++;
         end
         if (b_in_valid && b_in_ready) sent++;
         @(negedge clk);
      end
      b_in_valid = 1'b0;
      check("stream.rcvd", 32'(rcvd), 32'd8);
      check("stream.no_dup", 32'(b_out_valid), 32'd0);

      // fill primary and skid, then flush alongside a new bundle
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      drive2(10);
      @(negedge clk);
      drive2(11);
      @(negedge clk);
      check("full.in_ready", 32'(b_in_ready), 32'd0);
      check("full.imm0", b_out_imm[31:0], 32'd10);
      drive2(12);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush.out_valid", 32'(b_out_valid), 32'd0);
      check("flush.in_ready", 32'(b_in_ready), 32'd1);
      drive2(13);
      b_out_ready = 1'b1;
      @(negedge clk);
      b_in_valid = 1'b0;
      check("post_flush.valid", 32'(b_out_valid), 32'd1);
      check("post_flush.imm0", b_out_imm[31:0], 32'd13);
      @(negedge clk);
      check("post_flush.drained", 32'(b_out_valid), 32'd0);

      // bundle offered with flush while ready is discarded
      drive2(14);
      b_in_valid = 1'b1;
      flush      = 1'b1;
      @(negedge clk);
      flush      = 1'b0;
      b_in_valid = 1'b0;
      check("flush_in.out_valid", 32'(b_out_valid), 32'd0);
      @(negedge clk);
      check("flush_in.still_empty", 32'(b_out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
